// File: rtl/fetch_cycle_sequencer.sv
// fetch_cycle_sequencer
//   Generates the eight-state machine cycle A1 A2 A3 M1 M2 X1 X2 X3 that times
//   the 4-bit datapath. It owns the 12-bit program counter, puts the PC nibbles
//   on the shared bus during A1-A3, and captures the OPR/OPA nibbles in M1/M2.
//   The fetched byte is routed either to the instruction register (first word)
//   or to the operand register (second word of a two-word opcode).
//
// Ports
//   clk_2             system clock, one state per rising edge
//   reset             asynchronous active-high reset
//   data_bus_in       ROM nibble, sampled in M1 (OPR) and M2 (OPA)
//   data_bus_out/oe   PC nibble driven during A1-A3, otherwise 0 / low
//   jump_load/addr    sampled in X3, replaces the next PC
//   halt              sampled in X3 (enter HALT) and in HALT (stay)
//   sync              high during X3
//   cycle_state       A1=0 .. X3=7, HALT also reads 7
//   pc                current program counter
//   instruction(_valid) last first word, pulse in X1
//   operand(_valid)     last second word, pulse in X1
//   second_word       current cycle fetches a second word
module fetch_cycle_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk_2,
    input  logic        reset,
    input  logic [3:0]  data_bus_in,
    output logic [3:0]  data_bus_out,
    output logic        data_bus_oe,
    input  logic        jump_load,
    input  logic [11:0] jump_addr,
    input  logic        halt,
    output logic        sync,
    output logic [2:0]  cycle_state,
    output logic [11:0] pc,
    output logic [7:0]  instruction,
    output logic        instruction_valid,
    output logic [7:0]  operand,
    output logic        operand_valid,
    output logic        second_word
);

    localparam logic [3:0] S_A1   = 4'd0;
    localparam logic [3:0] S_A2   = 4'd1;
    localparam logic [3:0] S_A3   = 4'd2;
    localparam logic [3:0] S_M1   = 4'd3;
    localparam logic [3:0] S_M2   = 4'd4;
    localparam logic [3:0] S_X1   = 4'd5;
    localparam logic [3:0] S_X2   = 4'd6;
    localparam logic [3:0] S_X3   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0] state;
    logic [3:0] opr_reg;

    // Opcodes that are followed by a second ROM word.
    function automatic logic is_two_word(input logic [7:0] w);
        case (w[7:4])
            4'b0001, 4'b0100, 4'b0101, 4'b0111: is_two_word = 1'b1;
            4'b0010:                            is_two_word = ~w[0];
            default:                            is_two_word = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state       <= S_A1;
            pc          <= RESET_PC;
            opr_reg     <= 4'h0;
            instruction <= 8'h00;
            operand     <= 8'h00;
            second_word <= 1'b0;
        end else begin
            case (state)
                S_A1: state <= S_A2;
                S_A2: state <= S_A3;
                S_A3: state <= S_M1;
                S_M1: begin
                    opr_reg <= data_bus_in;
                    state   <= S_M2;
                end
                S_M2: begin
                    // The OPA nibble goes straight into the destination word.
                    if (second_word) operand     <= {opr_reg, data_bus_in};
                    else             instruction <= {opr_reg, data_bus_in};
                    pc    <= pc + 12'd1;
                    state <= S_X1;
                end
                S_X1: state <= S_X2;
                S_X2: state <= S_X3;
                S_X3: begin
                    if (jump_load) pc <= jump_addr;
                    // instruction here is the word fetched in this cycle when
                    // second_word is low; a second word never chains.
                    second_word <= second_word ? 1'b0 : is_two_word(instruction);
                    state       <= halt ? S_HALT : S_A1;
                end
                S_HALT: if (!halt) state <= S_A1;
                default: state <= S_A1;
            endcase
        end
    end

    assign cycle_state       = (state == S_HALT) ? 3'd7 : state[2:0];
    assign sync              = (state == S_X3);
    assign instruction_valid = (state == S_X1) && !second_word;
    assign operand_valid     = (state == S_X1) &&  second_word;

    // The bus is also released while reset is held, since the reset state
    // itself is A1.
    always_comb begin
        data_bus_out = 4'h0;
        data_bus_oe  = 1'b0;
        if (!reset) begin
            case (state)
                S_A1: begin data_bus_out = pc[3:0];  data_bus_oe = 1'b1; end
                S_A2: begin data_bus_out = pc[7:4];  data_bus_oe = 1'b1; end
                S_A3: begin data_bus_out = pc[11:8]; data_bus_oe = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_cycle_sequencer.sv
module tb_fetch_cycle_sequencer;

    logic        clk_2 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  data_bus_in = 4'h0;
    logic        jump_load = 1'b0;
    logic [11:0] jump_addr = 12'h000;
    logic        halt = 1'b0;
    logic [3:0]  data_bus_out;
    logic        data_bus_oe, sync, instruction_valid, operand_valid, second_word;
    logic [2:0]  cycle_state;
    logic [11:0] pc;
    logic [7:0]  instruction, operand;

    logic        reset2 = 1'b1;
    logic [3:0]  din2 = 4'h0;
    logic [3:0]  w_out;
    logic        w_oe, w_sync, w_iv, w_ov, w_sw;
    logic [2:0]  w_state;
    logic [11:0] w_pc;
    logic [7:0]  w_instr, w_oper;

    always #5 clk_2 = ~clk_2;

    fetch_cycle_sequencer u_dut (
        .clk_2(clk_2), .reset(reset), .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
        .jump_load(jump_load), .jump_addr(jump_addr), .halt(halt),
        .sync(sync), .cycle_state(cycle_state), .pc(pc),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .operand(operand), .operand_valid(operand_valid),
        .second_word(second_word)
    );

    fetch_cycle_sequencer #(.RESET_PC(12'hFFF)) u_wrap (
        .clk_2(clk_2), .reset(reset2), .data_bus_in(din2),
        .data_bus_out(w_out), .data_bus_oe(w_oe),
        .jump_load(1'b0), .jump_addr(12'h000), .halt(1'b0),
        .sync(w_sync), .cycle_state(w_state), .pc(w_pc),
        .instruction(w_instr), .instruction_valid(w_iv),
        .operand(w_oper), .operand_valid(w_ov), .second_word(w_sw)
    );

    wire [39:0] obs = {cycle_state, data_bus_oe, data_bus_out, sync, second_word,
                       instruction_valid, operand_valid, pc, instruction, operand};

    int n_tests = 0;
    int n_fail  = 0;
    string cur_test = "";

    logic [7:0]  rom [4096];
    logic [11:0] m_pc;
    logic [7:0]  m_instr, m_oper;
    logic        m_second;

    function automatic logic needs_operand(input logic [7:0] w);
        logic [3:0] opr;
        opr = w[7:4];
        return (opr == 4'd1) || (opr == 4'd4) || (opr == 4'd5) || (opr == 4'd7) ||
               (opr == 4'd2 && w[0] == 1'b0);
    endfunction

    task automatic do_cycle(input logic jl, input logic [11:0] ja,
                            input logic hl, input int hold);
        logic [7:0]  w;
        logic [3:0]  nib;
        logic [39:0] e;
        w = rom[m_pc];
        for (int s = 0; s < 8; s++) begin
            if (s == 5) begin
                m_pc = m_pc + 12'd1;
                if (m_second) m_oper = w; else m_instr = w;
            end
            case (s)
                0: nib = m_pc[3:0];
                1: nib = m_pc[7:4];
                2: nib = m_pc[11:8];
                default: nib = 4'h0;
            endcase
            e = {s[2:0], (s < 3), nib, (s == 7), m_second,
                 (s == 5 && !m_second), (s == 5 && m_second), m_pc, m_instr, m_oper};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s state%0d got %h exp %h", cur_test, s, obs, e);
            end
            data_bus_in = (s == 3) ? w[7:4] : (s == 4) ? w[3:0] : 4'($urandom);
            jump_load   = (s == 7) ? jl : 1'($urandom);
            jump_addr   = (s == 7) ? ja : 12'($urandom);
            halt        = (s == 7) ? hl : 1'($urandom);
            @(negedge clk_2);
        end
        if (m_second) m_second = 1'b0;
        else          m_second = needs_operand(m_instr);
        if (jl) m_pc = ja;
        if (hl) begin
            for (int h = 0; h < hold; h++) begin
                e = {3'd7, 1'b0, 4'h0, 1'b0, m_second, 1'b0, 1'b0, m_pc, m_instr, m_oper};
                n_tests++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL %s halt%0d got %h exp %h", cur_test, h, obs, e);
                end
                halt        = (h < hold - 1);
                jump_load   = 1'b1;
                jump_addr   = 12'($urandom);
                data_bus_in = 4'($urandom);
                @(negedge clk_2);
            end
        end
        jump_load = 1'b0;
        halt      = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_instr = 8'h00; m_oper = 8'h00; m_second = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        repeat (3) @(negedge clk_2);
        n_tests++;
        if (obs !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", obs, 40'h0);
        end
    endtask

    task automatic test_wrap();
        cur_test = "wrap";
        @(negedge clk_2);
        reset2 = 1'b0;
        #1;
        for (int s = 0; s < 8; s++) begin
            if (s < 3) begin
                n_tests++;
                if (w_out !== 4'hF || w_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_bus%0d got %h/%b exp f/1", s, w_out, w_oe);
                end
            end
            if (s == 5) begin
                n_tests++;
                if (w_pc !== 12'h000 || w_instr !== 8'h96 || w_iv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_pc got %h %h %b exp 000 96 1", w_pc, w_instr, w_iv);
                end
            end
            din2 = (s == 3) ? 4'h9 : (s == 4) ? 4'h6 : 4'($urandom);
            @(negedge clk_2);
        end
        reset2 = 1'b1;
    endtask

    task automatic test_basic();
        cur_test = "basic";
        model_reset();
        rom[0] = 8'hA5;
        reset = 1'b0;
        #1;
        do_cycle(1'b0, 12'h000, 1'b0, 0);
    endtask

    task automatic test_two_word();
        cur_test = "two_word";
        rom[m_pc]         = 8'h40;
        rom[m_pc + 12'd1] = 8'h3C;
        rom[m_pc + 12'd2] = 8'hD3;
        repeat (3) do_cycle(1'b0, 12'h000, 1'b0, 0);
    endtask

    task automatic test_jump();
        cur_test = "jump";
        rom[m_pc] = 8'hB1;
        do_cycle(1'b1, 12'h7E2, 1'b0, 0);
        do_cycle(1'b0, 12'h000, 1'b0, 0);
    endtask

    task automatic test_halt();
        cur_test = "halt";
        rom[m_pc] = 8'hC0;
        do_cycle(1'b0, 12'h000, 1'b1, 5);
        do_cycle(1'b0, 12'h000, 1'b0, 0);
        cur_test = "halt_jump";
        do_cycle(1'b1, 12'h5A9, 1'b1, 3);
        do_cycle(1'b0, 12'h000, 1'b0, 0);
    endtask

    task automatic test_random();
        cur_test = "random";
        for (int i = 0; i < 40; i++)
            do_cycle(($urandom_range(3) == 0), 12'($urandom),
                     ($urandom_range(6) == 0), $urandom_range(4, 1));
    endtask

    task automatic test_reset_mid();
        logic [39:0] e;
        cur_test = "reset_mid";
        rom[m_pc] = 8'h22;
        do_cycle(1'b0, 12'h000, 1'b0, 0);
        repeat (3) @(negedge clk_2);
        reset = 1'b1;
        #1;
        e = 40'h0;
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_state got %h exp %h", obs, e);
        end
        @(negedge clk_2);
        reset = 1'b0;
        #1;
        model_reset();
        do_cycle(1'b0, 12'h000, 1'b0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        test_reset();
        test_wrap();
        test_basic();
        test_two_word();
        test_jump();
        test_halt();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
